zx_paging_unit: RTL and testbench



---
 rtl/zx_paging_unit.sv | 185 ++++++++++++++++++
 tb/tb_zx_paging_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zx_paging_unit.sv
// Spectrum-family memory paging and divMMC automap controller.
// Decodes the 7FFD / 1FFD / E3 port writes, tracks M1 fetches for the
// divMMC automapper, and produces SDRAM / ROM addresses, the read-source
// select, the RAM write strobe, and the video / contention flags.
module zx_paging_unit #(
  parameter int RAM_BITS = 3,
  parameter bit PLUS3    = 1'b1,
  parameter bit DIVMMC   = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ce,
  input  logic                iorq,
  input  logic                mreq,
  input  logic                m1,
  input  logic                wr,
  input  logic                rd,
  input  logic [15:0]         a,
  input  logic [7:0]          d,
  output logic [RAM_BITS+14:0] sdrA,
  output logic [15:0]         romA,
  output logic [1:0]          src,
  output logic                ramWe,
  output logic                vduPage,
  output logic                contended,
  output logic                mapped
);

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DISARM} autoState_t;

  autoState_t          state, nextState;
  logic [RAM_BITS-1:0] ramPage, newPage, page;
  logic [1:0]          romPage, spMode, slot;
  logic                lock, special, mapForce, mapRam;
  logic [3:0]          mapPage, bank;
  logic                ioWr, wr7ffd, wr1ffd, wrE3;
  logic                m1Fetch, entryHit, rom3Hit, exitHit, rom3Sel;
  logic [2:0]          spPage;
  logic                overlay, writable;
  logic                unusedSig;

  // rd carries no information beyond wr for this block.
  assign unusedSig = rd;

  // Page number taken from a 7FFD write; the 512K variant adds d[7:6] on top.
  if (RAM_BITS == 5) begin : gPage512
    assign newPage = {d[7:6], d[2:0]};
  end else begin : gPage128
    assign newPage = RAM_BITS'(d[2:0]);
  end

  assign ioWr    = !iorq && !wr;
  assign wr7ffd  = ioWr && !a[15] && !a[1] && !lock;
  assign wr1ffd  = PLUS3 && ioWr && (a[15:12] == 4'b0001) && !a[1] && !lock;
  assign wrE3    = DIVMMC && ioWr && (a[7:0] == 8'hE3);
  assign m1Fetch = !mreq && !m1;
  assign rom3Sel = PLUS3 ? (romPage == 2'd3) : 1'b1;
  assign entryHit = m1Fetch && (a inside {16'h0000, 16'h0008, 16'h0038,
                                          16'h0066, 16'h04C6, 16'h0562});
  assign rom3Hit  = m1Fetch && (a[15:8] == 8'h3D) && rom3Sel;
  assign exitHit  = m1Fetch && (a[15:3] == 13'h03FF);

  // Paging and divMMC control registers, loaded by port writes on ce.
  always_ff @(posedge clock) begin
    if (reset) begin
      ramPage  <= '0;
      romPage  <= '0;
      vduPage  <= 1'b0;
      lock     <= 1'b0;
      special  <= 1'b0;
      spMode   <= '0;
      mapForce <= 1'b0;
      mapRam   <= 1'b0;
      mapPage  <= '0;
    end else if (ce) begin
      if (wr7ffd) begin
        ramPage    <= newPage;
        vduPage    <= d[3];
        romPage[0] <= d[4];
        lock       <= d[5];
      end
      if (wr1ffd) begin
        special    <= d[0];
        spMode     <= d[2:1];
        romPage[1] <= d[2];
      end
      if (wrE3) begin
        mapForce <= d[7];
        mapPage  <= d[3:0];
        mapRam   <= mapRam | d[6];
      end
    end
  end

  // Automap state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else if (ce) begin
      state <= nextState;
    end
  end

  // Automap next state: entry points arm until the fetch ends, the ROM3
  // 3Dxx trap maps at once, and the 1FF8-1FFF exit unmaps after its fetch.
  always_comb begin
    nextState = state;
    if (DIVMMC) begin
      case (state)
        IDLE:    if (rom3Hit) nextState = ACTIVE;
                 else if (entryHit) nextState = ARM;
        ARM:     if (rom3Hit || m1) nextState = ACTIVE;
                 else if (exitHit) nextState = IDLE;
        ACTIVE:  if (exitHit) nextState = DISARM;
        DISARM:  if (m1) nextState = IDLE;
                 else if (entryHit) nextState = ACTIVE;
        default: nextState = IDLE;
      endcase
    end
  end

  // Automap output: overlay visible while active, while disarming, or forced.
  always_comb begin
    mapped = DIVMMC && (mapForce || (state == ACTIVE) || (state == DISARM));
  end

  // Address translation, read source, write strobe and contention per access.
  always_comb begin
    slot = a[15:14];
    case (spMode)
      2'b00:   spPage = {1'b0, slot};
      2'b01:   spPage = {1'b1, slot};
      2'b10:   spPage = (slot == 2'd3) ? 3'd3 : {1'b1, slot};
      default: spPage = (slot == 2'd3) ? 3'd3 : (slot == 2'd1) ? 3'd7 : {1'b1, slot};
    endcase

    overlay   = 1'b0;
    bank      = mapPage;
    page      = '0;
    writable  = 1'b1;
    src       = 2'd2;
    contended = 1'b0;
    if (special) begin
      page      = RAM_BITS'(spPage);
      contended = spPage[2];
    end else begin
      case (slot)
        2'd0: begin
          if (mapped) begin
            overlay = 1'b1;
            if (!a[13]) begin
              // Lower 8K is esxDOS ROM, or read-only bank 3 once mapRam is set.
              bank     = 4'd3;
              writable = 1'b0;
              if (!mapRam) src = 2'd1;
            end
          end else begin
            src      = 2'd0;
            writable = 1'b0;
          end
        end
        2'd1: begin
          page      = RAM_BITS'(5);
          contended = 1'b1;
        end
        2'd2: page = RAM_BITS'(2);
        default: begin
          page      = ramPage;
          contended = ramPage[0];
        end
      endcase
    end

    sdrA = {1'b0, page, a[13:0]};
    if (overlay) begin
      sdrA                 = '0;
      sdrA[RAM_BITS+14]    = 1'b1;
      sdrA[16:13]          = bank;
      sdrA[12:0]           = a[12:0];
    end
    ramWe = !mreq && !wr && writable;
    romA  = {(PLUS3 ? romPage[1] : 1'b0), romPage[0], a[13:0]};
  end

endmodule

// File: tb/tb_zx_paging_unit.sv
// Bench for zx_paging_unit: directed steps followed by random bus traffic,
// checked against a behavioural paging / automap model. A 128K and a 512K
// instance share the same stimulus.
module tb_zx_paging_unit;

  logic        clock = 1'b0;
  logic        reset, ce, iorq, mreq, m1, wr, rd;
  logic [15:0] a;
  logic [7:0]  d;
  logic [17:0] sdrA;
  logic [15:0] romA;
  logic [1:0]  src;
  logic        ramWe, vduPage, contended, mapped;
  logic [19:0] sdrA5;
  logic [15:0] romA5;
  logic [1:0]  src5;
  logic        ramWe5, vduPage5, contended5, mapped5;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state.
  logic [7:0] m7ffd;
  logic [1:0] mRom, mSpMode;
  logic [3:0] mMapPage;
  bit         mLock, mSpecial, mForce, mMapRam, isMapped, pending;
  int         spTable [4][4] = '{'{0, 1, 2, 3}, '{4, 5, 6, 7}, '{4, 5, 6, 3}, '{4, 7, 6, 3}};
  logic [15:0] entries [6] = '{16'h0000, 16'h0008, 16'h0038, 16'h0066, 16'h04C6, 16'h0562};

  zx_paging_unit dut (
    .clock(clock), .reset(reset), .ce(ce), .iorq(iorq), .mreq(mreq), .m1(m1),
    .wr(wr), .rd(rd), .a(a), .d(d), .sdrA(sdrA), .romA(romA), .src(src),
    .ramWe(ramWe), .vduPage(vduPage), .contended(contended), .mapped(mapped)
  );

  zx_paging_unit #(.RAM_BITS(5), .PLUS3(1'b1), .DIVMMC(1'b1)) dut5 (
    .clock(clock), .reset(reset), .ce(ce), .iorq(iorq), .mreq(mreq), .m1(m1),
    .wr(wr), .rd(rd), .a(a), .d(d), .sdrA(sdrA5), .romA(romA5), .src(src5),
    .ramWe(ramWe5), .vduPage(vduPage5), .contended(contended5), .mapped(mapped5)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic modelReset();
    m7ffd = '0; mRom = '0; mSpMode = '0; mMapPage = '0;
    mLock = 0; mSpecial = 0; mForce = 0; mMapRam = 0; isMapped = 0; pending = 0;
  endtask

  task automatic modelIo(input logic [15:0] port, input logic [7:0] data);
    bit h7, h1, hE;
    h7 = !port[15] && !port[1] && !mLock;
    h1 = (port[15:12] == 4'h1) && !port[1] && !mLock;
    hE = (port[7:0] == 8'hE3);
    if (h7) begin m7ffd = data; mRom[0] = data[4]; mLock = data[5]; end
    if (h1) begin mSpecial = data[0]; mSpMode = data[2:1]; mRom[1] = data[2]; end
    if (hE) begin mForce = data[7]; mMapPage = data[3:0]; if (data[6]) mMapRam = 1; end
  endtask

  // isMapped: overlay currently on; pending: a toggle waits for m1 to rise.
  task automatic modelFetch(input logic [15:0] addr);
    bit entry, exitA, r3;
    entry = 0;
    foreach (entries[k]) if (entries[k] == addr) entry = 1;
    r3    = (addr[15:8] == 8'h3D) && (mRom == 2'd3);
    exitA = (addr >= 16'h1FF8) && (addr <= 16'h1FFF);
    if (!isMapped) begin
      if (r3) begin isMapped = 1; pending = 0; end
      else if (entry) pending = 1;
      else if (exitA) pending = 0;
    end else if (pending) begin
      if (entry) pending = 0;
    end else if (exitA) begin
      pending = 1;
    end
  endtask

  task automatic modelM1High();
    if (pending) begin isMapped = !isMapped; pending = 0; end
  endtask

  task automatic checkBus(input string tag, input logic [15:0] addr, input bit isWrite);
    int slot, pg3, pg5, bank, expSrc, exp3, exp5;
    bit ok, ovl, cont, mapOn;
    slot  = int'(addr[15:14]);
    mapOn = mForce || isMapped;
    ok = 1; ovl = 0; cont = 0; expSrc = 2; bank = 0; pg3 = 0; pg5 = 0;
    if (mSpecial) begin
      pg3 = spTable[mSpMode][slot]; pg5 = pg3; cont = (pg3 >= 4);
    end else if (slot == 0) begin
      if (mapOn) begin
        ovl = 1;
        if (addr < 16'h2000) begin ok = 0; bank = 3; if (!mMapRam) expSrc = 1; end
        else bank = int'(mMapPage);
      end else begin
        ok = 0; expSrc = 0;
      end
    end else if (slot == 1) begin
      pg3 = 5; pg5 = 5; cont = 1;
    end else if (slot == 2) begin
      pg3 = 2; pg5 = 2;
    end else begin
      pg3 = int'(m7ffd[2:0]); pg5 = int'(m7ffd[7:6]) * 8 + pg3; cont = m7ffd[0];
    end
    if (ovl) begin
      exp3 = (1 << 17) + bank * 8192 + int'(addr[12:0]);
      exp5 = (1 << 19) + bank * 8192 + int'(addr[12:0]);
    end else begin
      exp3 = pg3 * 16384 + int'(addr[13:0]);
      exp5 = pg5 * 16384 + int'(addr[13:0]);
    end
    chk({tag, ".src"}, 32'(src), expSrc);
    chk({tag, ".src5"}, 32'(src5), expSrc);
    chk({tag, ".ramWe"}, 32'(ramWe), 32'(isWrite && ok));
    chk({tag, ".romA"}, 32'(romA), int'(mRom) * 16384 + int'(addr[13:0]));
    chk({tag, ".contended"}, 32'(contended), 32'(cont));
    chk({tag, ".mapped"}, 32'(mapped), 32'(mapOn));
    chk({tag, ".vduPage"}, 32'(vduPage), 32'(m7ffd[3]));
    if (expSrc == 2) begin
      chk({tag, ".sdrA"}, 32'(sdrA), exp3);
      chk({tag, ".sdrA5"}, 32'(sdrA5), exp5);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic busIdle();
    iorq = 1; mreq = 1; m1 = 1; wr = 1; rd = 1;
  endtask

  task automatic doReset(input bit ceVal);
    ce = ceVal; reset = 1; busIdle();
    tick();
    reset = 0; ce = 1;
    modelReset();
  endtask

  task automatic ioWrite(input logic [15:0] port, input logic [7:0] data, input bit ceVal);
    ce = ceVal; iorq = 0; wr = 0; rd = 1; mreq = 1; m1 = 1; a = port; d = data;
    tick();
    if (ceVal) begin
      modelIo(port, data);
      modelM1High();
    end
    busIdle(); ce = 1;
  endtask

  task automatic memAccess(input logic [15:0] addr, input bit isWrite, input string tag);
    mreq = 0; m1 = 1; iorq = 1; wr = !isWrite; rd = isWrite; a = addr; d = 8'($urandom);
    @(negedge clock);
    checkBus(tag, addr, isWrite);
    tick();
    modelM1High();
    busIdle();
  endtask

  // Access with an absolute expected SDRAM address for both instances.
  task automatic spot(input logic [15:0] addr, input bit isWrite, input string tag,
                      input logic [31:0] want3, input logic [31:0] want5);
    mreq = 0; m1 = 1; iorq = 1; wr = !isWrite; rd = isWrite; a = addr;
    @(negedge clock);
    chk({tag, ".sdrA"}, 32'(sdrA), want3);
    chk({tag, ".sdrA5"}, 32'(sdrA5), want5);
    tick();
    modelM1High();
    busIdle();
  endtask

  task automatic m1Fetch(input logic [15:0] addr, input string tag, input bit followIdle);
    mreq = 0; m1 = 0; rd = 0; wr = 1; iorq = 1; a = addr;
    @(negedge clock);
    checkBus(tag, addr, 1'b0);
    tick();
    modelFetch(addr);
    if (followIdle) begin
      busIdle();
      @(negedge clock);
      checkBus({tag, ".after"}, addr, 1'b0);
      tick();
      modelM1High();
    end
  endtask

  initial begin
    reset = 1; ce = 1; a = '0; d = '0;
    busIdle();
    modelReset();
    tick();
    tick();
    reset = 0;

    memAccess(16'h0000, 0, "rst.rom");
    memAccess(16'hC000, 0, "rst.ram");

    ioWrite(16'h7FFD, 8'h17, 1);
    memAccess(16'hC123, 1, "p7.wr");
    spot(16'hC123, 1, "p7.abs", 32'h1C123, 32'h1C123);

    ioWrite(16'h7FFD, 8'h20, 1);
    ioWrite(16'h7FFD, 8'h07, 1);
    ioWrite(16'h1FFD, 8'h01, 1);
    memAccess(16'hC000, 0, "lock.page");
    memAccess(16'h0000, 0, "lock.rom");

    doReset(1);
    ioWrite(16'h1FFD, 8'h07, 1);
    memAccess(16'h0000, 1, "sp.s0");
    spot(16'h0000, 1, "sp.abs", 32'h10000, 32'h10000);
    memAccess(16'h4000, 0, "sp.s1");
    memAccess(16'hC000, 0, "sp.s3");
    ioWrite(16'h1FFD, 8'h00, 1);

    m1Fetch(16'h0038, "am.entry", 1);
    memAccess(16'h0010, 0, "am.esx");
    memAccess(16'h0010, 1, "am.esxwr");
    m1Fetch(16'h1FF8, "am.exit", 1);
    memAccess(16'h0010, 0, "am.off");
    ioWrite(16'h1FFD, 8'h14, 1);
    m1Fetch(16'h3D00, "am.rom3", 1);
    m1Fetch(16'h0066, "am.nmi", 1);
    m1Fetch(16'h1FF8, "am.dis", 0);
    m1Fetch(16'h0000, "am.reent", 1);
    memAccess(16'h0100, 0, "am.still");
    m1Fetch(16'h1FFF, "am.exit2", 1);
    m1Fetch(16'h0008, "am.arm", 0);
    m1Fetch(16'h1FFC, "am.cancel", 1);
    memAccess(16'h0100, 0, "am.idle");

    // Paging write and entry fetch on the same ce.
    iorq = 0; wr = 0; mreq = 0; m1 = 0; rd = 1; a = 16'h0038; d = 8'h03;
    tick();
    modelFetch(16'h0038);
    modelIo(16'h0038, 8'h03);
    busIdle();
    @(negedge clock);
    checkBus("sim.idle", a, 1'b0);
    tick();
    modelM1High();
    memAccess(16'hC000, 0, "sim.page");
    m1Fetch(16'h1FF8, "sim.exit", 1);

    ioWrite(16'h00E3, 8'h43, 1);
    memAccess(16'h2000, 1, "e3.nomap");
    ioWrite(16'h00E3, 8'hC3, 1);
    memAccess(16'h2000, 1, "e3.wr");
    spot(16'h2000, 1, "e3.abs", 32'h26000, 32'h86000);
    memAccess(16'h0100, 1, "e3.ro");
    ioWrite(16'h00E3, 8'h00, 1);
    memAccess(16'h0100, 0, "e3.unforced");

    doReset(1);
    ioWrite(16'h7FFD, 8'hC1, 1);
    memAccess(16'hC000, 0, "p25");
    spot(16'hC000, 0, "p25.abs", 32'h04000, 32'h64000);
    ioWrite(16'h7FFD, 8'h05, 0);
    memAccess(16'hC000, 0, "ce0.hold");
    ioWrite(16'h00E3, 8'h80, 1);
    memAccess(16'h0000, 0, "force");
    doReset(0);
    memAccess(16'h0000, 0, "rst.ce0");
    memAccess(16'hC000, 0, "rst.ce0ram");

    for (int i = 0; i < 300; i++) begin
      logic [7:0]  rd8;
      logic [15:0] ra;
      int          op;
      op  = int'($urandom_range(0, 11));
      rd8 = 8'($urandom);
      ra  = 16'($urandom);
      case (op)
        0: ioWrite(16'h7FFD, ($urandom_range(0, 9) == 0) ? rd8 : (rd8 & 8'hDF), 1);
        1: ioWrite(16'h1FFD, ($urandom_range(0, 9) == 0) ? rd8 : (rd8 & 8'hDF), 1);
        2: ioWrite({ra[15:8], 8'hE3}, rd8, 1);
        3: ioWrite(16'h7FFD, rd8 & 8'hDF, 1'($urandom_range(0, 1)));
        4, 5, 6: memAccess(ra, 1'($urandom_range(0, 1)), "rnd.mem");
        7: m1Fetch(entries[$urandom_range(0, 5)], "rnd.entry", 1'($urandom_range(0, 1)));
        8: m1Fetch(16'h1FF8 + 16'($urandom_range(0, 7)), "rnd.exit", 1'($urandom_range(0, 1)));
        9: m1Fetch({8'h3D, ra[7:0]}, "rnd.rom3", 1'($urandom_range(0, 1)));
        10: m1Fetch(ra, "rnd.fetch", 1);
        default: begin
          if ($urandom_range(0, 3) == 0) doReset(1'($urandom_range(0, 1)));
          else memAccess(ra, 0, "rnd.rd");
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
